// File: rtl/fifo_to_axi.sv
// fifo_to_axi: unpacks phased 192-bit FIFO words into 256-bit AXI4-Stream beats (option: UNPACK_PHASE_CHECK_EN)
module fifo_to_axi #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [200:0]             fifo_dout,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [TUSER_WIDTH-1:0]   tuser_dout,
  input  logic                     tuser_empty,
  output logic                     tuser_rd_en,
  output logic                     tvalid,
  input  logic                     tready,
  output logic [8*TDATA_WIDTH-1:0] tdata,
  output logic [TDATA_WIDTH-1:0]   tstrb,
  output logic [TDATA_WIDTH-1:0]   tkeep,
  output logic                     tlast,
  output logic [TUSER_WIDTH-1:0]   tuser,
  output logic [31:0]              output_beat_cnt,
  output logic                     phase_err
);
  localparam int DW = 8 * TDATA_WIDTH;
  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;
  phase_t                 r_phase;
  phase_t                 w_phase;
  phase_t                 w_next;
  logic [191:0]           r_residue;
  logic                   r_full;
  logic [DW-1:0]          r_data;
  logic [TDATA_WIDTH-1:0] r_strb;
  logic                   r_last;
  logic [31:0]            r_cnt;
  logic [191:0]           w_payload;
  logic [4:0]             w_count;
  logic                   w_last;
  logic                   w_accept;
  logic                   w_load;
  logic [DW-1:0]          w_beat;
  logic [TDATA_WIDTH-1:0] w_strb;
  logic                   w_unused;
  assign w_payload = fifo_dout[200:9];
  assign w_count   = fifo_dout[8:4];
  assign w_last    = fifo_dout[1];
  assign w_unused  = ^{fifo_dout[3:0]};
`ifdef UNPACK_PHASE_CHECK_EN
  assign w_phase = phase_t'(fifo_dout[3:2]);
`else
  assign w_phase = r_phase;
`endif
  // Gate handshakes during reset so no word or beat is consumed while state is being cleared
  assign tvalid      = ~reset & r_full & ~tuser_empty;
  assign w_accept    = tvalid & tready;
  assign fifo_rd_en  = ~reset & ~fifo_empty & (w_phase == PH0 | ~r_full | w_accept);
  assign w_load      = fifo_rd_en & (w_phase != PH0);
  assign tuser_rd_en = w_accept & r_last;
  assign tdata       = r_data;
  assign tstrb       = r_strb;
  assign tkeep       = r_strb;
  assign tlast       = r_last;
  assign tuser       = tuser_dout;
  assign output_beat_cnt = r_cnt;
  // Beat assembly from residue and payload, byte mask, and next expected phase
  always_comb begin
    w_beat = (w_phase == PH1) ? {w_payload[63:0], r_residue} :
             (w_phase == PH2) ? {w_payload[127:0], r_residue[127:0]} :
                                {w_payload, r_residue[63:0]};
    w_strb = (w_count == 5'd0) ? {TDATA_WIDTH{1'b1}} : ~({TDATA_WIDTH{1'b1}} << w_count);
    w_next = (w_phase == PH0) ? PH1 :
             (w_phase == PH3 || w_last) ? PH0 : phase_t'(w_phase + 2'd1);
  end
  // Phase state, residue, output register and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase   <= PH0;
      r_residue <= '0;
      r_full    <= 1'b0;
      r_data    <= '0;
      r_strb    <= '0;
      r_last    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (fifo_rd_en) begin
        r_phase <= w_next;
        if (w_phase == PH0) r_residue <= w_payload;
        else if (w_phase == PH1) r_residue[127:0] <= w_payload[191:64];
        else if (w_phase == PH2) r_residue[63:0] <= w_payload[191:128];
      end
      if (w_load) begin
        r_data <= w_beat;
        r_strb <= w_strb;
        r_last <= w_last;
      end
      r_full <= w_load | (r_full & ~w_accept);
      if (w_accept) r_cnt <= r_cnt + 32'd1;
    end
  end
`ifdef UNPACK_PHASE_CHECK_EN
  // Sticky flag for a popped word whose phase field disagrees with the expected phase
  always_ff @(posedge clk) begin
    if (reset) phase_err <= 1'b0;
    else if (fifo_rd_en && fifo_dout[3:2] != r_phase) phase_err <= 1'b1;
  end
`else
  assign phase_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_to_axi.sv
// tb_fifo_to_axi: randomized scoreboard bench for fifo_to_axi
module tb_fifo_to_axi;
  logic         clk = 1'b0;
  logic         reset;
  logic [200:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [127:0] tuser_dout;
  logic         tuser_empty;
  logic         tuser_rd_en;
  logic         tvalid;
  logic         tready;
  logic [255:0] tdata;
  logic [31:0]  tstrb;
  logic [31:0]  tkeep;
  logic         tlast;
  logic [127:0] tuser;
  logic [31:0]  output_beat_cnt;
  logic         phase_err;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  s;
    logic         l;
    logic [127:0] u;
  } beat_t;

  logic [200:0] wq[$];
  logic [127:0] uq[$];
  beat_t        exq[$];
  int errors = 0;
  int checks = 0;
  int tot_beats = 0;
  int rdy_pct = 100;
  logic hold_u = 1'b0;
  logic rdy_block = 1'b0;

  fifo_to_axi dut (
    .clk(clk), .reset(reset),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .tuser_dout(tuser_dout), .tuser_empty(tuser_empty), .tuser_rd_en(tuser_rd_en),
    .tvalid(tvalid), .tready(tready), .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep),
    .tlast(tlast), .tuser(tuser), .output_beat_cnt(output_beat_cnt), .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [31:0] strb_of(input logic [4:0] c);
    logic [31:0] s;
    for (int i = 0; i < 32; i++) s[i] = (c == 5'd0) || (i < int'(c));
    return s;
  endfunction

  // Reference packing: beats of a packet are laid end to end in groups of three,
  // and word i of a group carries bits [192*i +: 192] of that group
  task automatic send_packet(input int n, input logic [4:0] cnt, input logic [127:0] u, input bit expect_out);
    logic [255:0] b[$];
    logic [767:0] g;
    logic [191:0] p;
    logic         lst;
    int k;
    int m;
    for (int i = 0; i < n; i++) begin
      b.push_back(rnd256());
      if (expect_out) exq.push_back('{b[i], strb_of(i == n - 1 ? cnt : 5'd0), i == n - 1, u});
    end
    if (expect_out) begin
      uq.push_back(u);
      tot_beats += n;
    end
    k = 0;
    while (k < n) begin
      m = (n - k > 3) ? 3 : n - k;
      g = '0;
      for (int j = 0; j < m; j++) g[256*j +: 256] = b[k+j];
      for (int i = 0; i <= m; i++) begin
        p = g[192*i +: 192];
        lst = (i > 0) && (k + i - 1 == n - 1);
        if (i == 0) wq.push_back({p, 5'($urandom()), 2'd0, 1'($urandom()), 1'($urandom())});
        else wq.push_back({p, lst ? cnt : 5'd0, 2'(i), lst, 1'($urandom())});
      end
      k += m;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exq.size() > 0 || wq.size() > 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // FIFO models: pops follow the read enables seen mid-cycle, inputs change just after the edge
  initial begin
    logic pf;
    logic pu;
    forever begin
      @(negedge clk);
      pf = fifo_rd_en;
      pu = tuser_rd_en;
      @(posedge clk);
      #1;
      if (pf && wq.size() > 0) void'(wq.pop_front());
      if (pu && uq.size() > 0) void'(uq.pop_front());
      fifo_empty  = (wq.size() == 0);
      fifo_dout   = (wq.size() > 0) ? wq[0] : '0;
      tuser_empty = hold_u || (uq.size() == 0);
      tuser_dout  = (uq.size() > 0) ? uq[0] : '0;
      tready      = !rdy_block && ($urandom_range(99) < rdy_pct);
    end
  end

  // Monitor: every accepted beat is matched against the scoreboard head
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (tvalid) chk("tvalid_tuser_present", tuser_empty, 0);
      if (tvalid && tready) begin
        if (exq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", tdata);
        end else begin
          e = exq.pop_front();
          chk("tdata", tdata, e.d);
          chk("tstrb", tstrb, e.s);
          chk("tkeep", tkeep, e.s);
          chk("tlast", tlast, e.l);
          chk("tuser", tuser, e.u);
          chk("tuser_rd_en", tuser_rd_en, e.l);
        end
      end else if (tuser_rd_en) begin
        checks++;
        errors++;
        $display("FAIL tuser_rd_en_idle: got 1 expected 0");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] p0;
    logic [255:0] p1;
    logic [127:0] u;
    int t;
    reset = 1'b1; fifo_dout = '0; fifo_empty = 1'b1;
    tuser_dout = '0; tuser_empty = 1'b1; tready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_cnt", output_beat_cnt, 0);
    chk("rst_phase_err", phase_err, 0);
    chk("rst_tuser_rd_en", tuser_rd_en, 0);
    // Three full beats, last one with count 0
    rdy_pct = 100;
    send_packet(3, 5'd0, 128'hA5, 1);
    drain();
    chk("cnt_three", output_beat_cnt, 3);
    // Single-beat packet with 5 valid bytes
    send_packet(1, 5'd5, 128'hB6, 1);
    drain();
    chk("tuser_popped", uq.size(), 0);
    chk("cnt_single", output_beat_cnt, tot_beats);
    // Back-pressure for ten cycles mid-packet
    send_packet(3, 5'd0, 128'hC7, 1);
    repeat (3) @(negedge clk);
    rdy_block = 1'b1;
    repeat (10) @(negedge clk);
    rdy_block = 1'b0;
    drain();
    chk("cnt_stall", output_beat_cnt, tot_beats);
    // Metadata absent holds tvalid low; its arrival raises tvalid in the same cycle
    hold_u = 1'b1;
    send_packet(1, 5'd0, 128'hD8, 1);
    repeat (10) @(negedge clk);
    chk("tvalid_wait_tuser", tvalid, 0);
    hold_u = 1'b0;
    @(posedge clk);
    #2;
    chk("tvalid_tuser_arrives", tvalid, 1);
    drain();
    // Random packets with random back-pressure
    for (int i = 0; i < 40; i++) begin
      rdy_pct = $urandom_range(100, 20);
      u = {$urandom(), $urandom(), $urandom(), $urandom()};
      send_packet($urandom_range(7, 1), 5'($urandom()), u, 1);
      if (i % 8 == 7) drain();
    end
    drain();
    chk("cnt_random", output_beat_cnt, tot_beats);
    // Reset after the phase-1 word of a packet discards the partial state
    rdy_pct = 0;
    p0 = rnd256();
    p1 = rnd256();
    wq.push_back({p0[191:0], 5'd0, 2'd0, 2'b00});
    wq.push_back({p1[191:0], 5'd0, 2'd1, 2'b00});
    t = 0;
    while (wq.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("partial_words_popped", wq.size(), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_cnt", output_beat_cnt, 0);
    tot_beats = 0;
    rdy_pct = 100;
    send_packet(3, 5'd0, 128'hE9, 1);
    drain();
    chk("cnt_after_rst", output_beat_cnt, 3);
    // Word carrying phase 2 while phase 1 is expected
    p0 = rnd256();
    p1 = rnd256();
    wq.push_back({p0[191:0], 5'd0, 2'd0, 2'b00});
    wq.push_back({p1[191:0], 5'd0, 2'd2, 2'b10});
    uq.push_back(128'hF0);
`ifdef UNPACK_PHASE_CHECK_EN
    exq.push_back('{{p1[127:0], p0[127:0]}, 32'hFFFFFFFF, 1'b1, 128'hF0});
`else
    exq.push_back('{{p1[63:0], p0[191:0]}, 32'hFFFFFFFF, 1'b1, 128'hF0});
`endif
    tot_beats += 1;
    drain();
`ifdef UNPACK_PHASE_CHECK_EN
    chk("phase_err_set", phase_err, 1);
    repeat (5) @(negedge clk);
    chk("phase_err_sticky", phase_err, 1);
`else
    chk("phase_err_tied", phase_err, 0);
`endif
    chk("cnt_phase", output_beat_cnt, tot_beats);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("final_rst_phase_err", phase_err, 0);
    chk("final_rst_cnt", output_beat_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_to_axi.md
FIFO_TO_AXI -- requirements
Module: fifo_to_axi

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 32: AXI data bus width in bytes; only 32 is supported.
REQ-002 SHALL have parameter TUSER_WIDTH, default 128: TUSER width in bits.
REQ-003 SHALL have port clk  input  1: single clock for all logic.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port fifo_dout  input  201: packed word, first-word-fall-through, valid whenever fifo_empty=0.
REQ-006 SHALL have port fifo_empty  input  1: packed-word FIFO empty.
REQ-007 SHALL have port fifo_rd_en  output  1: pops one packed word.
REQ-008 SHALL have port tuser_dout  input  TUSER_WIDTH: per-packet metadata, FWFT.
REQ-009 SHALL have port tuser_empty  input  1: metadata FIFO empty.
REQ-010 SHALL have port tuser_rd_en  output  1: pops one metadata entry.
REQ-011 SHALL have ports tvalid output 1, tready input 1, tdata output 256, tstrb output 32, tkeep output 32, tlast output 1, tuser output TUSER_WIDTH: AXI4-Stream master.
REQ-012 SHALL have port output_beat_cnt  output  32: count of accepted output beats.
REQ-013 SHALL have port phase_err  output  1: sticky packing-phase mismatch flag.

Function
REQ-014 Word format SHALL be: [200:9] payload (192b), [8:4] byte count of completed beat (0 = 32 bytes), [3:2] phase, [1] last flag of completed beat, [0] ignored.
REQ-015 Unpacker SHALL hold expected phase (2b) and a 192-bit residue register.
REQ-016 Phase 0 word: residue <= payload[191:0]; no beat emitted; next phase 1.
REQ-017 Phase 1 word: emit {payload[63:0], residue[191:0]}; residue[127:0] <= payload[191:64]; next phase 2, or phase 0 if last flag set.
REQ-018 Phase 2 word: emit {payload[127:0], residue[127:0]}; residue[63:0] <= payload[191:128]; next phase 3, or phase 0 if last flag set.
REQ-019 Phase 3 word: emit {payload[191:0], residue[63:0]}; next phase 0.
REQ-020 Emitted beat SHALL load a single output register; tvalid SHALL assert the cycle after the pop.
REQ-021 tstrb and tkeep SHALL equal 32'hFFFFFFFF for byte count 0, else the low N bytes set; tlast SHALL equal the word's last flag.
REQ-022 fifo_rd_en SHALL be ~fifo_empty and (phase 0 expected, or output register empty, or output beat accepted this cycle).
REQ-023 tvalid SHALL assert only when the output register is full and tuser_empty=0; tuser SHALL equal tuser_dout.
REQ-024 tuser_rd_en SHALL pulse for one cycle on the tvalid&tready&tlast handshake.
REQ-025 tdata, tstrb, tkeep, tlast SHALL be stable while tvalid=1 and tready=0.
REQ-026 A simultaneous accept and load SHALL sustain one beat per cycle without bubbles.
REQ-027 output_beat_cnt SHALL increment by 1 per tvalid&tready and wrap at 2^32-1 to 0.

Reset
REQ-028 Reset SHALL clear tvalid, fifo_rd_en, tuser_rd_en, output_beat_cnt, phase_err, residue and output register to 0 and set expected phase to 0, taking effect on the next clk edge.
REQ-029 Reset mid-packet SHALL discard the partial beat and residue; no beat is emitted until a new phase-0 word arrives.

Configuration
REQ-030 With UNPACK_PHASE_CHECK_EN defined, a popped word whose phase field differs from the expected phase SHALL set phase_err (sticky until reset) and SHALL be processed as its own phase, resynchronising.
REQ-031 Without UNPACK_PHASE_CHECK_EN, the phase field SHALL be ignored, the internal expected phase used, and phase_err tied to 0.

Verification
REQ-032 Three 256-bit beats A,B,C (C last, count 0) packed as phases 0-3 -> beats A,B,C out in order, tstrb FFFFFFFF, tlast on C only, output_beat_cnt=3.
REQ-033 Single-beat packet, words phase 0 then phase 1 with last=1 and count 5 -> one beat, tstrb 0000001F, tlast=1, tuser_rd_en pulses once; next phase expected 0.
REQ-034 tready held 0 for 10 cycles mid-packet -> tdata stable, fifo_rd_en=0 for completing phases, no beat lost or duplicated.
REQ-035 tuser_empty=1 with output register full -> tvalid=0; tuser_empty falls -> tvalid=1 the same cycle.
REQ-036 Reset asserted after phase 1 word -> tvalid=0 next cycle; a fresh 0-1-2-3 sequence emits exactly 3 correct beats.
REQ-037 With UNPACK_PHASE_CHECK_EN, phase 2 word sent when phase 1 expected -> phase_err=1 and held until reset; without the macro -> phase_err=0.
